// File: rtl/tnnzeq_sample_sequencer.sv
// Sequences one ternary-weight sweep into a downstream accumulator: clear, stream
// +/- selected features, then a one-cycle done pulse. All outputs are registered.
module tnnzeq_sample_sequencer #(
  parameter int unsigned FEAT = 4,
  parameter int unsigned BITS = 8,
  parameter int unsigned SIZE = 4,
  parameter logic [((SIZE > 0) ? SIZE : 1) * ((FEAT > 1) ? $clog2(FEAT) : 1) - 1:0] IDX = '0,
  parameter logic [((SIZE > 0) ? SIZE : 1) - 1:0] NEG = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [FEAT*BITS-1:0]   features,
  output logic                   ready,
  output logic                   acc_clr,
  output logic signed [BITS:0]   sample,
  output logic                   halt,
  output logic                   last,
  output logic                   done
);

  localparam int unsigned IW = (FEAT > 1) ? $clog2(FEAT) : 1;
  localparam int unsigned KW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [KW-1:0] LASTK = KW'((SIZE > 0) ? SIZE - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                state_q;
  logic [KW-1:0]         k_q;
  logic [FEAT*BITS-1:0]  feat_q;

  logic [KW-1:0]         k_nxt;
  logic signed [BITS:0]  x;
  logic signed [BITS:0]  smp_nxt;
  logic                  last_nxt;

  // Sample for the step about to be presented; unmatched (out-of-range) indices give 0.
  always_comb begin
    k_nxt    = (state_q == ST_STREAM) ? k_q + KW'(1) : '0;
    x        = '0;
    smp_nxt  = '0;
    for (int j = 0; j < int'(SIZE); j++) begin
      if (k_nxt == KW'(j)) begin
        for (int f = 0; f < int'(FEAT); f++) begin
          if (IDX[j*IW +: IW] == IW'(f)) begin
            x       = {1'b0, feat_q[f*BITS +: BITS]};
            smp_nxt = NEG[j] ? -x : x;
          end
        end
      end
    end
    last_nxt = (k_nxt == LASTK);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      feat_q  <= '0;
      ready   <= 1'b1;
      acc_clr <= 1'b0;
      sample  <= '0;
      halt    <= 1'b1;
      last    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CLEAR;
            feat_q  <= features;
            ready   <= 1'b0;
            acc_clr <= 1'b1;
          end
        end
        ST_CLEAR: begin
          acc_clr <= 1'b0;
          if (SIZE != 0) begin
            state_q <= ST_STREAM;
            k_q     <= '0;
            halt    <= 1'b0;
            sample  <= smp_nxt;
            last    <= last_nxt;
          end else begin
            state_q <= ST_DONE;
            done    <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (k_q == LASTK) begin
            state_q <= ST_DONE;
            halt    <= 1'b1;
            sample  <= '0;
            last    <= 1'b0;
            done    <= 1'b1;
          end else begin
            k_q    <= k_nxt;
            sample <= smp_nxt;
            last   <= last_nxt;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done    <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tnnzeq_sample_sequencer.sv
// Scoreboard bench for tnnzeq_sample_sequencer: a SIZE=3 build with an accumulator-style
// sample model plus a SIZE=0 build checked for its CLEAR->DONE-only sweep.
module tb_tnnzeq_sample_sequencer;

  localparam int FEAT = 4;
  localparam int BITS = 8;
  localparam int SIZE = 3;
  localparam int IDX_L [SIZE] = '{0, 3, 2};
  localparam bit NEG_L [SIZE] = '{1'b0, 1'b1, 1'b0};

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  start = 1'b0;
  logic                  start0 = 1'b0;
  logic [FEAT*BITS-1:0]  features = '0;

  logic                  ready, acc_clr, halt, last, done;
  logic signed [BITS:0]  sample;
  logic                  ready0, acc_clr0, halt0, last0, done0;
  logic signed [BITS:0]  sample0;

  tnnzeq_sample_sequencer #(
    .FEAT(FEAT), .BITS(BITS), .SIZE(SIZE), .IDX(6'b10_11_00), .NEG(3'b010)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .features(features),
    .ready(ready), .acc_clr(acc_clr), .sample(sample), .halt(halt),
    .last(last), .done(done)
  );

  tnnzeq_sample_sequencer #(
    .FEAT(FEAT), .BITS(BITS), .SIZE(0), .IDX(2'b00), .NEG(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .features(features),
    .ready(ready0), .acc_clr(acc_clr0), .sample(sample0), .halt(halt0),
    .last(last0), .done(done0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit mon_en   = 1'b0;

  int samp_q [$];
  bit last_q [$];
  int clr_q  [$];
  int done_q [$];
  int clr0_q [$];
  int done0_q[$];
  int busy_lo = -1, busy_hi = -2, next_ok = 0, next_ok0 = 0;

  task automatic check(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  // Reference: signed weight times the selected feature, index beyond FEAT reads as 0.
  function automatic int model_sample(input logic [FEAT*BITS-1:0] fv, input int k);
    int idx;
    int xv;
    idx = IDX_L[k];
    xv  = (idx < FEAT) ? int'(fv[idx*BITS +: BITS]) : 0;
    return NEG_L[k] ? -xv : xv;
  endfunction

  // Called at posedge+2; inputs apply to the upcoming edge, whose index is cyc.
  task automatic drive(input bit st, input bit st0, input logic [FEAT*BITS-1:0] fv);
    int e;
    start    = st;
    start0   = st0;
    features = fv;
    e = cyc;
    if (st && rst_n && e >= next_ok) begin
      clr_q.push_back(e + 1);
      for (int k = 0; k < SIZE; k++) begin
        samp_q.push_back(model_sample(fv, k));
        last_q.push_back(k == SIZE - 1);
      end
      done_q.push_back(e + SIZE + 2);
      busy_lo = e + 1;
      busy_hi = e + SIZE + 2;
      next_ok = e + SIZE + 3;
    end
    if (st0 && rst_n && e >= next_ok0) begin
      clr0_q.push_back(e + 1);
      done0_q.push_back(e + 2);
      next_ok0 = e + 3;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    start0 = 1'b0;
    @(posedge clk);
    #2;
    samp_q.delete(); last_q.delete(); clr_q.delete(); done_q.delete();
    clr0_q.delete(); done0_q.delete();
    busy_lo  = -1;
    busy_hi  = -2;
    next_ok  = cyc;
    next_ok0 = cyc;
    check("rst_ready",   ready,       1);
    check("rst_halt",    halt,        1);
    check("rst_acc_clr", acc_clr,     0);
    check("rst_sample",  int'(sample), 0);
    check("rst_last",    last,        0);
    check("rst_done",    done,        0);
    check("rst_ready0",  ready0,      1);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      check("ready", ready, int'(!(cyc >= busy_lo && cyc <= busy_hi)));
      if (acc_clr) begin
        if (clr_q.size() > 0) check("acc_clr_cycle", cyc, clr_q.pop_front());
        else check("acc_clr_pending", clr_q.size(), 1);
        check("halt_in_clear", halt, 1);
      end
      if (!halt) begin
        if (samp_q.size() > 0) begin
          check("sample", int'(sample), samp_q.pop_front());
          check("last", last, int'(last_q.pop_front()));
        end else check("sample_pending", samp_q.size(), 1);
      end else begin
        check("last_halted", last, 0);
        check("sample_halted", int'(sample), 0);
      end
      if (done) begin
        if (done_q.size() > 0) check("done_cycle", cyc, done_q.pop_front());
        else check("done_pending", done_q.size(), 1);
      end
      check("size0_halt", halt0, 1);
      check("size0_last", last0, 0);
      if (acc_clr0) begin
        if (clr0_q.size() > 0) check("size0_clr_cycle", cyc, clr0_q.pop_front());
        else check("size0_clr_pending", clr0_q.size(), 1);
      end
      if (done0) begin
        if (done0_q.size() > 0) check("size0_done_cycle", cyc, done0_q.pop_front());
        else check("size0_done_pending", done0_q.size(), 1);
      end
    end
  end

  initial begin
    logic [FEAT*BITS-1:0] fva;
    logic [FEAT*BITS-1:0] fvb;
    fva = {8'd255, 8'd30, 8'd20, 8'd10};
    fvb = {8'd0, 8'd1, 8'd77, 8'd255};

    do_reset();
    do_reset();
    mon_en = 1'b1;

    // Directed sweeps: mixed signs, then max positive plus zero feature.
    drive(1'b1, 1'b1, fva);
    repeat (8) drive(1'b0, 1'b0, fva);
    drive(1'b1, 1'b0, fvb);
    repeat (7) drive(1'b0, 1'b0, $urandom);

    // start held high: back-to-back sweeps with one ready cycle between.
    repeat (20) drive(1'b1, 1'b1, $urandom);
    repeat (6) drive(1'b0, 1'b0, $urandom);

    // Reset during the second STREAM cycle, then a clean rerun of the first sweep.
    drive(1'b1, 1'b0, fva);
    drive(1'b0, 1'b0, fva);
    drive(1'b0, 1'b0, fva);
    do_reset();
    drive(1'b1, 1'b0, fva);
    repeat (8) drive(1'b0, 1'b0, $urandom);

    // Random traffic with occasional mid-sweep resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else drive($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, $urandom);
    end

    for (int i = 0; i < 20 && (done_q.size() > 0 || done0_q.size() > 0); i++)
      drive(1'b0, 1'b0, $urandom);
    #1;
    check("samples_left", samp_q.size(), 0);
    check("done_left",    done_q.size(), 0);
    check("done0_left",   done0_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
